// File: rtl/asip_pkg.sv
// Shared definitions for the ASIP run-control unit: run states and the
// default debounce interval.
package asip_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } run_state_t;

  // Stable-sample count before a button level is accepted (1 ms at 50 MHz).
  localparam int DB_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/button_debouncer.sv
// Button conditioning for one active-low board button: 2-flop synchroniser,
// stable-sample counter, debounced level and a one-cycle press pulse on the
// 1->0 transition of the debounced level.
module button_debouncer #(
  parameter int DB_CYCLES = asip_pkg::DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchroniser; idles high because the button is active-low.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that differ from the accepted level; accept the
  // new level after DB_CYCLES of them and pulse when it falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= level_q;  // only a 1->0 acceptance is a press
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/asip_run_control.sv
// Run-control unit for the pipelined ASIP: debounced power/debug/step buttons
// drive a clock-enable state machine (OFF/RUN/HALT/STEP) with multi-cycle
// single-step, resume and an optional PC breakpoint.
// Define RUN_CTRL_BP_EN to build the breakpoint comparator and skip flag;
// without it bp_addr/bp_valid are ignored and the ports are kept.
module asip_run_control
  import asip_pkg::*;
#(
  parameter int N         = 24,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwr,
  input  logic              dbg,
  input  logic              stp,
  input  logic [STEP_W-1:0] step_len,
  input  logic [N-1:0]      pc,
  input  logic [N-1:0]      bp_addr,
  input  logic              bp_valid,
  output logic              en,
  output logic              cpu_rst,
  output logic [1:0]        state,
  output logic              halted,
  output logic [31:0]       cycle_count,
  output logic              out
);

  run_state_t        state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [31:0]       cycle_count_q;
  logic              cc_clear;
  logic              bp_hit;
  logic              run_en;

  logic pwr_p, dbg_p, stp_p;
  logic dbg_lvl;
  logic unused_pwr_lvl, unused_stp_lvl;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_pwr_db (
    .clk(clk), .rst(rst), .btn_i(pwr), .level_o(unused_pwr_lvl), .press_o(pwr_p)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_dbg_db (
    .clk(clk), .rst(rst), .btn_i(dbg), .level_o(dbg_lvl), .press_o(dbg_p)
  );
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_stp_db (
    .clk(clk), .rst(rst), .btn_i(stp), .level_o(unused_stp_lvl), .press_o(stp_p)
  );

  // Enable is decoded from the state register; a breakpoint hit masks it in
  // the same cycle so the processor does not advance past bp_addr.
  assign run_en = (state_q == RUN) || (state_q == STEP);
  assign en     = run_en && !bp_hit;

`ifdef RUN_CTRL_BP_EN
  logic bp_skip_q;

  assign bp_hit = (state_q == RUN) && bp_valid && (pc == bp_addr) && !bp_skip_q;

  // Skip flag lets a resume step off the breakpoint address: set on
  // HALT->RUN, cleared once RUN has actually advanced one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_skip_q <= 1'b0;
    end else if (state_q == HALT && state_d == RUN) begin
      bp_skip_q <= 1'b1;
    end else if (state_q == RUN && en) begin
      bp_skip_q <= 1'b0;
    end
  end
`else
  logic unused_bp;

  assign bp_hit    = 1'b0;
  assign unused_bp = ^{bp_valid, bp_addr, pc};
`endif

  // Next-state logic; priority pwr_p > breakpoint > stp_p > dbg_p.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    cc_clear   = 1'b0;
    unique case (state_q)
      OFF: begin
        if (pwr_p) begin
          cc_clear = 1'b1;
          state_d  = dbg_lvl ? RUN : HALT;  // debug held at power-on: start halted
        end
      end
      RUN: begin
        if (pwr_p)       state_d = OFF;
        else if (bp_hit) state_d = HALT;
        else if (stp_p)  state_d = HALT;
      end
      HALT: begin
        if (pwr_p) begin
          state_d = OFF;
        end else if (stp_p) begin
          state_d    = STEP;
          step_cnt_d = (step_len == '0) ? STEP_W'(1) : step_len;
        end else if (dbg_p) begin
          state_d = RUN;
        end
      end
      STEP: begin
        if (pwr_p) begin
          state_d    = OFF;
          step_cnt_d = '0;
        end else if (step_cnt_q <= STEP_W'(1)) begin
          state_d    = HALT;
          step_cnt_d = '0;
        end else begin
          step_cnt_d = step_cnt_q - STEP_W'(1);
        end
      end
      default: state_d = OFF;
    endcase
  end

  // State and step-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= OFF;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  // Enabled-cycle counter, cleared at power-on, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_q <= '0;
    end else if (cc_clear) begin
      cycle_count_q <= '0;
    end else if (en) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign cpu_rst     = (state_q == OFF);
  assign state       = state_q;
  assign halted      = (state_q == HALT);
  assign out         = halted;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_asip_run_control.sv
// Directed testbench for asip_run_control with a short debounce interval.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_asip_run_control;

  localparam int N      = 24;
  localparam int DB     = 4;
  localparam int STEP_W = 8;

  logic              clk, rst, pwr, dbg, stp, bp_valid;
  logic [STEP_W-1:0] step_len;
  logic [N-1:0]      pc, bp_addr;
  logic              en, cpu_rst, halted, out_led;
  logic [1:0]        state;
  logic [31:0]       cycle_count;

  int checks   = 0;
  int failures = 0;

  asip_run_control #(.N(N), .DB_CYCLES(DB), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp),
    .step_len(step_len), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .en(en), .cpu_rst(cpu_rst), .state(state), .halted(halted),
    .cycle_count(cycle_count), .out(out_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; pwr = 1'b1; dbg = 1'b1; stp = 1'b1;
    step_len = 8'd1; pc = 24'h0; bp_addr = 24'h0; bp_valid = 1'b0;
    tick(2);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", en); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    checks++; if (halted !== 1'b0 || out_led !== 1'b0) begin failures++; $display("FAIL reset_halted_out: got %b/%b expected 0/0", halted, out_led); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
    rst = 1'b0;
    tick(10);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL idle_off: got %0d expected 0", state); end
  endtask

  // Power press from OFF: pulse after 6 edges, RUN on the 7th.
  task automatic test_power_on;
    pwr = 1'b0;
    tick(6);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL pwr_latency_early: got %0d expected 0", state); end
    tick(1);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL pwr_on_state: got %0d expected 1", state); end
    checks++; if (en !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("FAIL pwr_on_en_rst: got %b/%b expected 1/0", en, cpu_rst); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL pwr_on_cc: got %0d expected 0", cycle_count); end
    tick(3);
    pwr = 1'b1;
    tick(8);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL pwr_held_once: got %0d expected 1", state); end
    checks++; if (cycle_count !== 32'd11) begin failures++; $display("FAIL run_cc: got %0d expected 11", cycle_count); end
  endtask

  // Short stp glitch is rejected; a held stp halts after the debounce latency.
  task automatic test_glitch_and_halt;
    stp = 1'b0;
    tick(2);
    stp = 1'b1;
    tick(10);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL glitch_ignored: got %0d expected 1", state); end
    stp = 1'b0;
    tick(6);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL stp_latency_early: got %0d expected 1", state); end
    tick(1);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL halt_state: got %0d expected 2", state); end
    checks++; if (out_led !== 1'b1 || halted !== 1'b1 || en !== 1'b0) begin failures++; $display("FAIL halt_outputs: got out=%b halted=%b en=%b expected 1/1/0", out_led, halted, en); end
    tick(1);
    stp = 1'b1;
    tick(8);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL halt_hold: got %0d expected 2", state); end
    checks++; if (cycle_count !== 32'd30) begin failures++; $display("FAIL halt_cc: got %0d expected 30", cycle_count); end
  endtask

  task automatic test_step(input logic [7:0] len, input int exp_n, input logic [31:0] exp_cc);
    int n;
    step_len = len;
    stp = 1'b0;
    tick(6);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL step_pre_len%0d: got %0d expected 2", len, state); end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i == 0) begin
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL step_enter_len%0d: got %0d expected 3", len, state); end
      end
      if (en === 1'b1) n++;
    end
    checks++; if (n !== exp_n) begin failures++; $display("FAIL step_en_cycles_len%0d: got %0d expected %0d", len, n, exp_n); end
    stp = 1'b1;
    tick(8);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL step_back_halt_len%0d: got %0d expected 2", len, state); end
    checks++; if (cycle_count !== exp_cc) begin failures++; $display("FAIL step_cc_len%0d: got %0d expected %0d", len, cycle_count, exp_cc); end
  endtask

  task automatic test_breakpoint;
    bp_valid = 1'b1; bp_addr = 24'h000010; pc = 24'h00000C;
    dbg = 1'b0;
    tick(6);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL resume_early: got %0d expected 2", state); end
    tick(1);
    checks++; if (state !== 2'd1 || en !== 1'b1) begin failures++; $display("FAIL resume_run: got state=%0d en=%b expected 1/1", state, en); end
    tick(1);
    dbg = 1'b1;
    tick(8);
    pc = 24'h000010;
    #1;
`ifdef RUN_CTRL_BP_EN
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL bp_mask_en: got %b expected 0", en); end
    tick(1);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL bp_halt: got %0d expected 2", state); end
    dbg = 1'b0;
    tick(7);
    checks++; if (state !== 2'd1 || en !== 1'b1) begin failures++; $display("FAIL bp_skip_resume: got state=%0d en=%b expected 1/1", state, en); end
    tick(1);
    pc = 24'h000014;
    #1;
    checks++; if (state !== 2'd1 || en !== 1'b1) begin failures++; $display("FAIL bp_moved_on: got state=%0d en=%b expected 1/1", state, en); end
    dbg = 1'b1;
    tick(8);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bp_stay_run: got %0d expected 1", state); end
`else
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL bp_disabled_en: got %b expected 1", en); end
    tick(1);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bp_disabled_state: got %0d expected 1", state); end
    pc = 24'h000014;
`endif
    bp_valid = 1'b0;
  endtask

  // Simultaneous power and stop presses in RUN: power wins.
  task automatic test_pwr_priority;
    pwr = 1'b0; stp = 1'b0;
    tick(6);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL prio_early: got %0d expected 1", state); end
    tick(1);
    checks++; if (state !== 2'd0 || cpu_rst !== 1'b1 || en !== 1'b0) begin failures++; $display("FAIL prio_off: got state=%0d cpu_rst=%b en=%b expected 0/1/0", state, cpu_rst, en); end
    tick(1);
    pwr = 1'b1; stp = 1'b1;
    tick(8);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL prio_stay_off: got %0d expected 0", state); end
  endtask

  // Debug held at power-on starts halted and clears the cycle counter.
  task automatic test_dbg_power_on;
    dbg = 1'b0;
    tick(8);
    pwr = 1'b0;
    tick(7);
    checks++; if (state !== 2'd2 || cpu_rst !== 1'b0 || en !== 1'b0) begin failures++; $display("FAIL dbg_pwr_halt: got state=%0d cpu_rst=%b en=%b expected 2/0/0", state, cpu_rst, en); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL dbg_pwr_cc_clear: got %0d expected 0", cycle_count); end
    tick(1);
    pwr = 1'b1; dbg = 1'b1;
    tick(8);
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL dbg_pwr_stay: got %0d expected 2", state); end
  endtask

  task automatic test_async_reset;
    step_len = 8'd5;
    stp = 1'b0;
    tick(7);
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL rst_step_enter: got %0d expected 3", state); end
    tick(2);
    checks++; if (en !== 1'b1 || cycle_count !== 32'd2) begin failures++; $display("FAIL rst_mid_step: got en=%b cc=%0d expected 1/2", en, cycle_count); end
    rst = 1'b1;
    #1;
    checks++; if (state !== 2'd0 || en !== 1'b0) begin failures++; $display("FAIL async_rst_state_en: got state=%0d en=%b expected 0/0", state, en); end
    checks++; if (cpu_rst !== 1'b1 || halted !== 1'b0 || cycle_count !== 32'd0) begin failures++; $display("FAIL async_rst_outputs: got cpu_rst=%b halted=%b cc=%0d expected 1/0/0", cpu_rst, halted, cycle_count); end
    stp = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL post_rst_off: got %0d expected 0", state); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_glitch_and_halt();
    test_step(8'd3, 3, 32'd33);
    test_step(8'd0, 1, 32'd34);
    test_breakpoint();
    test_pwr_priority();
    test_dbg_power_on();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/asip_run_control.md
# asip_run_control

Run-control unit for the pipelined ASIP. It sits between the board buttons and the processor and replaces the latched-enable, gated-clock start-up scheme with a clock-enable state machine. It adds button debouncing, debug halt, multi-cycle single-step, resume and a PC breakpoint. The processor and memory run on the free-running clock and advance only while `en` is high.

## Interface

Parameters:
- `N`, 24, PC width (matches the processor datapath)
- `DB_CYCLES`, 50000, cycles a synchronised button level must be stable before it is accepted
- `STEP_W`, 8, width of the step-length input

Ports:
- `clk`  in  1  system clock, free-running, never gated
- `rst`  in  1  asynchronous, active-high reset
- `pwr`  in  1  raw power button, active-low
- `dbg`  in  1  raw debug/resume button, active-low
- `stp`  in  1  raw stop/step button, active-low
- `step_len`  in  STEP_W  processor cycles per step; 0 is treated as 1
- `pc`  in  N  current processor PC
- `bp_addr`  in  N  breakpoint address
- `bp_valid`  in  1  breakpoint armed
- `en`  out  1  processor/memory clock enable
- `cpu_rst`  out  1  processor reset, active-high
- `state`  out  2  current run state
- `halted`  out  1  high in HALT
- `cycle_count`  out  32  number of cycles with `en` high since the last power-on
- `out`  out  1  status LED; equal to `halted`

## Operation

- Each button path: 2-flop synchroniser, then a stable counter up to `DB_CYCLES`. The debounced level updates only after `DB_CYCLES` consecutive equal samples. A 1→0 transition of the debounced level produces a one-cycle press pulse (`pwr_p`, `dbg_p`, `stp_p`).
- States: OFF=0, RUN=1, HALT=2, STEP=3.
- **OFF:** `en`=0, `cpu_rst`=1.
  - On `pwr_p`, clear `cycle_count`.
  - If debounced `dbg` is held low at that moment, go to HALT; otherwise go to RUN.
- **RUN:** `en`=1 unless the breakpoint hits, `cpu_rst`=0.
  - `stp_p` → HALT.
  - A breakpoint hit (`bp_valid` && `pc`==`bp_addr` && !`bp_skip`) → HALT. `en` is forced low combinationally in the hit cycle, so the instruction at `bp_addr` is not fetched past.
- **HALT:** `en`=0, `cpu_rst`=0.
  - `stp_p` → STEP; load the step counter with `max(step_len,1)`.
  - `dbg_p` → RUN; set `bp_skip`.
- **STEP:** `en`=1. Decrement the step counter each cycle. At count 1 → HALT.
  - `stp_p` and `dbg_p` are ignored.
  - Breakpoints are not checked.
- `bp_skip`: set on HALT→RUN, cleared after the first RUN cycle with `en`=1. This lets resume leave a breakpoint address.
- `pwr_p` in RUN, HALT or STEP → OFF. This is a power toggle.
- Priority within one cycle: `pwr_p` > breakpoint > `stp_p` > `dbg_p`.
- `cycle_count` increments on every cycle with `en`=1 and wraps at 2^32.

## Timing

- Reset values:
  - state=OFF, `en`=0, `cpu_rst`=1, `halted`=0, `out`=0, `cycle_count`=0
  - debouncer levels=1, step counter=0, `bp_skip`=0
- Press latency: the `*_p` pulse fires `DB_CYCLES`+2 cycles after the raw pin first goes stably low. The state changes on the next edge.
- `en` is a registered decode of state, except for the combinational breakpoint mask.
- A step of `step_len`=k gives exactly k cycles with `en`=1.
- Bounces shorter than `DB_CYCLES` produce no pulse. A held button produces exactly one pulse.
- An asynchronous `rst` in any state returns all outputs to their reset values immediately; any partial debounce count is discarded.

## Configuration

- `RUN_CTRL_BP_EN` defined: breakpoint compare and `bp_skip` are present as described.
- Not defined: the compare is not built, `bp_addr`/`bp_valid` are ignored, the hit term is constant 0, and the ports remain so the top level is unchanged.

## Structure

- Shared package `asip_pkg`:
  - `run_state_t` enum (OFF, RUN, HALT, STEP)
  - default `DB_CYCLES`
- Sub-module `button_debouncer`, instantiated three times. It holds the synchroniser, stable counter, debounced level and falling-edge pulse.

## Test plan

Benches use `DB_CYCLES`=4.

- Reset, then hold `pwr` low for 10 cycles → `pwr_p` fires 6 cycles after `pwr` falls; the next edge gives state=RUN, `en`=1, `cpu_rst`=0.
- In RUN, a `stp` glitch low for 2 cycles → no pulse, state stays RUN. `stp` held low for 8 cycles → HALT, `out`=1, `en`=0.
- In HALT with `step_len`=3, press `stp` → exactly 3 cycles with `en`=1, `cycle_count` +3, back in HALT. With `step_len`=0 → exactly 1 cycle.
- `bp_valid`=1, `bp_addr`=0x000010, drive `pc` to 0x000010 in RUN → `en`=0 in that cycle, then HALT. Press `dbg` → RUN, `en`=1 while `pc` is still 0x000010, and `pc` moves on.
- `pwr_p` and `stp_p` in the same cycle in RUN → OFF, `cpu_rst`=1.
- Assert `rst` mid-STEP → `en`=0, state=OFF immediately.
